calc_stack_n: RTL and testbench
===============================

# calc_stack_n

Parametrised operand stack for the RPN calculator datapath: a next-generation stack with configurable word width and depth, and a richer opcode set (dup, swap, binary-reduce, clear). The top two entries live in registers, so `top` and `next` are always valid for the ALU. Deeper entries live in an inferred synchronous single-port block RAM. It sits between the command decoder (which issues opcodes) and the ALU and display logic (which consume `top`, `next`, `size` and `error`).

## Interface
- `WIDTH`, default 32: data word width.
- `ADDR_W`, default 9: RAM address width. Capacity is DEPTH = 2**ADDR_W entries in total (registers plus RAM).
- `clk` input 1: clock.
- `reset` input 1: reset, synchronous, active-high.
- `op` input 3: opcode.
  - 0 NOP, 1 PUSH, 2 POP, 3 REPLACE, 4 DUP, 5 SWAP, 6 REDUCE, 7 CLEAR.
- `op_vld` input 1: opcode valid.
- `op_rdy` output 1: block can accept an opcode. Equals state==IDLE.
- `in_num` input WIDTH: operand for PUSH, REPLACE and REDUCE.
- `top` output WIDTH: entry at depth size-1. Reads 0 when size==0.
- `next` output WIDTH: entry at depth size-2. Reads 0 when size<2.
- `size` output ADDR_W+1: number of entries, range 0..DEPTH.
- `error` output 1: last accepted non-NOP op failed.
- `err_code` output 2: 0 none, 1 overflow, 2 underflow.

## Operation
- An op is accepted on a rising edge where `op_vld && op_rdy`. `op_vld` is ignored while `op_rdy` is low; the decoder holds or retries.
- States:
  - IDLE: accepts ops.
  - FETCH: a RAM read was issued last cycle; capture the RAM output into `next`, then return to IDLE.
- RAM layout: entry i for 0 ≤ i ≤ size-3 is stored at address i.
- Let S = `size` at acceptance. Each op acts as follows:
  - PUSH, S<DEPTH: if S≥2, write `next` to RAM[S-2]; then `next`<=`top`, `top`<=`in_num`, `size`<=S+1.
  - DUP, 1≤S<DEPTH: same as PUSH, with `top` as the pushed value.
  - POP, S≥1: `top`<=`next`, `size`<=S-1. If S≥3, read RAM[S-3] and go to FETCH; otherwise `next`<=0.
  - REPLACE, S≥1: `top`<=`in_num`.
  - SWAP, S≥2: exchange `top` and `next`.
  - REDUCE (pop two, push ALU result), S≥2: `top`<=`in_num`, `size`<=S-1. If S≥3, read RAM[S-3] and go to FETCH; otherwise `next`<=0.
  - CLEAR: `size`, `top` and `next` <= 0. RAM contents are don't-care.
  - NOP: no state change. `error` and `err_code` are held.
- Failed ops: the stack is left unchanged, `error`<=1, and `err_code` is set.
  - Overflow (1): PUSH or DUP at S==DEPTH.
  - Underflow (2): POP, REPLACE or DUP at S==0; SWAP or REDUCE at S<2.
- Any successful non-NOP op clears `error` and `err_code`.
- Arithmetic on `size` is unsigned, ADDR_W+1 bits. It never wraps, because guards precede every increment and decrement.

## Timing
- Reset values: `size`=0, `top`=0, `next`=0, `error`=0, `err_code`=0, state IDLE, `op_rdy`=1.
- Reset has priority over everything. Reset during FETCH aborts the read and returns to IDLE.
- Latency:
  - All ops update outputs on the acceptance edge. Exception: `next` for POP or REDUCE at S≥3.
  - For those, `op_rdy`=0 for exactly one cycle (FETCH), and `next` becomes valid on the following edge. Sustained throughput in that case is one op per 2 cycles.
- `size`, `top` and `error` are valid after the acceptance edge even when FETCH follows.
- RAM: read latency 1. A write and a read never occur in the same cycle.

## Configuration
- `CALC_STACK_HWM_EN` defined:
  - Adds output `max_size` (ADDR_W+1), the high-water mark of `size`.
  - Updated on the same edge as `size` whenever the new `size` exceeds it.
  - Reset to 0 by `reset` and by CLEAR.
- Undefined: the `max_size` port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset, then PUSH 5, PUSH 7, PUSH 9 -> `top`=9, `next`=7, `size`=3, `op_rdy` high throughout, `error`=0.
- From [5,7,9], POP -> `top`=7, `size`=2, `op_rdy`=0 for one cycle, then `next`=5. Then REDUCE 12 -> `top`=12, `next`=0, `size`=1.
- From [3,4], SWAP -> `top`=3, `next`=4. Then DUP -> `top`=3, `next`=3, `size`=3. Then POP -> `next`=4 after FETCH.
- Fill to DEPTH (ADDR_W=3, DEPTH=8), then PUSH -> `error`=1, `err_code`=1, `size`=8, `top` unchanged. A following POP -> `error`=0, `size`=7.
- Empty stack: POP, then SWAP with one entry -> each gives `err_code`=2 with the stack unchanged. A following NOP -> `error` still 1.
- Assert `reset` during FETCH -> `size`=0, `top`=0, `next`=0, `op_rdy`=1 next cycle. With HWM enabled: after 6 pushes and 3 pops, `max_size`=6; CLEAR -> `max_size`=0.

Source files
------------

// File: rtl/calc_stack_n.sv
// Parametrised RPN operand stack: top two entries in registers, deeper entries in a single-port RAM.
// Define CALC_STACK_HWM_EN to add the max_size high-water-mark output.
module calc_stack_n #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        op,
    input  logic              op_vld,
    output logic              op_rdy,
    input  logic [WIDTH-1:0]  in_num,
    output logic [WIDTH-1:0]  top,
    output logic [WIDTH-1:0]  next,
    output logic [ADDR_W:0]   size,
    output logic              error,
    output logic [1:0]        err_code
`ifdef CALC_STACK_HWM_EN
    ,
    output logic [ADDR_W:0]   max_size
`endif
);

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_PUSH    = 3'd1;
    localparam logic [2:0] OP_POP     = 3'd2;
    localparam logic [2:0] OP_REPLACE = 3'd3;
    localparam logic [2:0] OP_DUP     = 3'd4;
    localparam logic [2:0] OP_SWAP    = 3'd5;
    localparam logic [2:0] OP_REDUCE  = 3'd6;
    localparam logic [2:0] OP_CLEAR   = 3'd7;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_OVER  = 2'd1;
    localparam logic [1:0] ERR_UNDER = 2'd2;

    localparam logic [ADDR_W:0]   DEPTH   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   ONE     = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   TWO     = (ADDR_W+1)'(2);
    localparam logic [ADDR_W:0]   THREE   = (ADDR_W+1)'(3);
    localparam logic [ADDR_W-1:0] A_TWO   = (ADDR_W)'(2);
    localparam logic [ADDR_W-1:0] A_THREE = (ADDR_W)'(3);

    typedef enum logic {S_IDLE, S_FETCH} state_t;

    state_t            state, state_n;
    logic [WIDTH-1:0]  top_n, next_n, ram_rdata;
    logic [ADDR_W:0]   size_n;
    logic              error_n;
    logic [1:0]        code_n;
    logic              ram_we, ram_re;
    logic [ADDR_W-1:0] ram_addr;
    logic [WIDTH-1:0]  mem [0:(1<<ADDR_W)-1];

    assign op_rdy = (state == S_IDLE);

    always_comb begin
        state_n  = state;
        top_n    = top;
        next_n   = next;
        size_n   = size;
        error_n  = error;
        code_n   = err_code;
        ram_we   = 1'b0;
        ram_re   = 1'b0;
        ram_addr = size[ADDR_W-1:0] - A_TWO;
        if (state == S_FETCH) begin
            next_n  = ram_rdata;
            state_n = S_IDLE;
        end else if (op_vld) begin
            error_n = 1'b0;
            code_n  = ERR_NONE;
            case (op)
                OP_PUSH, OP_DUP: begin
                    if (size == DEPTH) begin
                        error_n = 1'b1;
                        code_n  = ERR_OVER;
                    end else if (op == OP_DUP && size == '0) begin
                        error_n = 1'b1;
                        code_n  = ERR_UNDER;
                    end else begin
                        // next spills to RAM[S-2] before it is overwritten by top
                        ram_we = (size >= TWO);
                        next_n = top;
                        top_n  = (op == OP_PUSH) ? in_num : top;
                        size_n = size + ONE;
                    end
                end
                OP_POP, OP_REDUCE: begin
                    if ((op == OP_POP && size == '0) || (op == OP_REDUCE && size < TWO)) begin
                        error_n = 1'b1;
                        code_n  = ERR_UNDER;
                    end else begin
                        top_n  = (op == OP_POP) ? next : in_num;
                        size_n = size - ONE;
                        if (size >= THREE) begin
                            ram_re   = 1'b1;
                            ram_addr = size[ADDR_W-1:0] - A_THREE;
                            state_n  = S_FETCH;
                        end else begin
                            next_n = '0;
                        end
                    end
                end
                OP_REPLACE: begin
                    if (size == '0) begin
                        error_n = 1'b1;
                        code_n  = ERR_UNDER;
                    end else begin
                        top_n = in_num;
                    end
                end
                OP_SWAP: begin
                    if (size < TWO) begin
                        error_n = 1'b1;
                        code_n  = ERR_UNDER;
                    end else begin
                        top_n  = next;
                        next_n = top;
                    end
                end
                OP_CLEAR: begin
                    top_n  = '0;
                    next_n = '0;
                    size_n = '0;
                end
                default: begin
                    error_n = error;
                    code_n  = err_code;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            top      <= '0;
            next     <= '0;
            size     <= '0;
            error    <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            state    <= state_n;
            top      <= top_n;
            next     <= next_n;
            size     <= size_n;
            error    <= error_n;
            err_code <= code_n;
        end
    end

    // Single-port RAM, read latency 1; writes and reads are mutually exclusive by construction
    always_ff @(posedge clk) begin
        if (ram_we)
            mem[ram_addr] <= next;
        if (ram_re)
            ram_rdata <= mem[ram_addr];
    end

`ifdef CALC_STACK_HWM_EN
    always_ff @(posedge clk) begin
        if (reset || (state == S_IDLE && op_vld && op == OP_CLEAR))
            max_size <= '0;
        else if (size_n > max_size)
            max_size <= size_n;
    end
`endif

endmodule

// File: tb/tb_calc_stack_n.sv
// Directed bench for calc_stack_n with a queue-backed reference stack and scoreboard.
module tb_calc_stack_n;

    localparam int WIDTH  = 32;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;

    localparam logic [2:0] OP_NOP = 3'd0, OP_PUSH = 3'd1, OP_POP = 3'd2, OP_REPLACE = 3'd3,
                           OP_DUP = 3'd4, OP_SWAP = 3'd5, OP_REDUCE = 3'd6, OP_CLEAR = 3'd7;

    logic              clk = 1'b0;
    logic              reset;
    logic [2:0]        op;
    logic              op_vld;
    logic              op_rdy;
    logic [WIDTH-1:0]  in_num;
    logic [WIDTH-1:0]  top;
    logic [WIDTH-1:0]  next;
    logic [ADDR_W:0]   size;
    logic              error;
    logic [1:0]        err_code;
`ifdef CALC_STACK_HWM_EN
    logic [ADDR_W:0]   max_size;
`endif

    calc_stack_n #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .op       (op),
        .op_vld   (op_vld),
        .op_rdy   (op_rdy),
        .in_num   (in_num),
        .top      (top),
        .next     (next),
        .size     (size),
        .error    (error),
        .err_code (err_code)
`ifdef CALC_STACK_HWM_EN
        ,
        .max_size (max_size)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] top;
        logic [31:0] nxt;
        logic [31:0] size;
        logic [31:0] err;
        logic [31:0] code;
        logic [31:0] hwm;
        bit          fetch;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m[$];
    int          merr, mcode, mhwm;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic [2:0] o, input logic [31:0] v);
        exp_t        e;
        int          s, cyc;
        logic [31:0] t;
        bit          fetch;
        @(negedge clk);
        cyc = 0;
        while (op_rdy !== 1'b1 && cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        if (op_rdy !== 1'b1) chk("rdy_timeout", 32'(op_rdy), 32'd1);
        s     = m.size();
        fetch = 1'b0;
        case (o)
            OP_PUSH: if (s < DEPTH) begin m.push_back(v); merr = 0; mcode = 0; end
                     else begin merr = 1; mcode = 1; end
            OP_DUP:  if (s == 0) begin merr = 1; mcode = 2; end
                     else if (s == DEPTH) begin merr = 1; mcode = 1; end
                     else begin m.push_back(m[s-1]); merr = 0; mcode = 0; end
            OP_POP:  if (s >= 1) begin t = m.pop_back(); fetch = (s >= 3); merr = 0; mcode = 0; end
                     else begin merr = 1; mcode = 2; end
            OP_REPLACE: if (s >= 1) begin m[s-1] = v; merr = 0; mcode = 0; end
                     else begin merr = 1; mcode = 2; end
            OP_SWAP: if (s >= 2) begin t = m[s-1]; m[s-1] = m[s-2]; m[s-2] = t; merr = 0; mcode = 0; end
                     else begin merr = 1; mcode = 2; end
            OP_REDUCE: if (s >= 2) begin
                         t = m.pop_back(); t = m.pop_back(); m.push_back(v);
                         fetch = (s >= 3); merr = 0; mcode = 0;
                     end else begin merr = 1; mcode = 2; end
            OP_CLEAR: begin m.delete(); merr = 0; mcode = 0; mhwm = 0; end
            default: ;
        endcase
        if (m.size() > mhwm) mhwm = m.size();
        e.size  = 32'(m.size());
        e.top   = (m.size() > 0) ? m[m.size()-1] : 32'd0;
        e.nxt   = (m.size() > 1) ? m[m.size()-2] : 32'd0;
        e.err   = 32'(merr);
        e.code  = 32'(mcode);
        e.hwm   = 32'(mhwm);
        e.fetch = fetch;
        sb.push_back(e);
        op     = o;
        in_num = v;
        op_vld = 1'b1;
        @(posedge clk);
        #1;
        op_vld = 1'b0;
        op     = OP_NOP;
        e = sb.pop_front();
        chk("top", top, e.top);
        chk("size", 32'(size), e.size);
        chk("error", 32'(error), e.err);
        chk("err_code", 32'(err_code), e.code);
`ifdef CALC_STACK_HWM_EN
        chk("max_size", 32'(max_size), e.hwm);
`endif
        if (e.fetch) begin
            chk("rdy_fetch", 32'(op_rdy), 32'd0);
            // an op offered during FETCH must be ignored
            op     = OP_CLEAR;
            op_vld = 1'b1;
            @(posedge clk);
            #1;
            op_vld = 1'b0;
            op     = OP_NOP;
            chk("size_after_fetch", 32'(size), e.size);
        end
        chk("next", next, e.nxt);
        chk("op_rdy", 32'(op_rdy), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        op     = OP_NOP;
        op_vld = 1'b0;
        in_num = '0;
        merr = 0; mcode = 0; mhwm = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_top", top, 32'd0);
        chk("rst_next", next, 32'd0);
        chk("rst_size", 32'(size), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_code", 32'(err_code), 32'd0);
        chk("rst_rdy", 32'(op_rdy), 32'd1);

        do_op(OP_PUSH, 32'd5);
        do_op(OP_PUSH, 32'd7);
        do_op(OP_PUSH, 32'd9);
        do_op(OP_POP, 32'd0);
        do_op(OP_REDUCE, 32'd12);

        do_op(OP_CLEAR, 32'd0);
        do_op(OP_PUSH, 32'd3);
        do_op(OP_PUSH, 32'd4);
        do_op(OP_SWAP, 32'd0);
        do_op(OP_DUP, 32'd0);
        do_op(OP_POP, 32'd0);

        do_op(OP_CLEAR, 32'd0);
        for (int i = 0; i < DEPTH; i++) do_op(OP_PUSH, 32'h100 + 32'(i));
        do_op(OP_PUSH, 32'd99);
        do_op(OP_DUP, 32'd0);
        do_op(OP_POP, 32'd0);
        do_op(OP_REPLACE, 32'h55);
        do_op(OP_NOP, 32'd0);
        for (int i = 0; i < 6; i++) do_op(OP_POP, 32'd0);
        do_op(OP_REDUCE, 32'h77);

        do_op(OP_CLEAR, 32'd0);
        do_op(OP_POP, 32'd0);
        do_op(OP_REPLACE, 32'd1);
        do_op(OP_DUP, 32'd0);
        do_op(OP_PUSH, 32'd1);
        do_op(OP_SWAP, 32'd0);
        do_op(OP_NOP, 32'd0);
        do_op(OP_REDUCE, 32'd2);
        do_op(OP_DUP, 32'd0);
        do_op(OP_REDUCE, 32'd2);

        do_op(OP_PUSH, 32'hA);
        do_op(OP_PUSH, 32'hB);
        @(negedge clk);
        op     = OP_POP;
        op_vld = 1'b1;
        @(posedge clk);
        #1;
        op_vld = 1'b0;
        op     = OP_NOP;
        chk("rf_in_fetch", 32'(op_rdy), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m.delete(); merr = 0; mcode = 0; mhwm = 0;
        chk("rf_size", 32'(size), 32'd0);
        chk("rf_top", top, 32'd0);
        chk("rf_next", next, 32'd0);
        chk("rf_rdy", 32'(op_rdy), 32'd1);
        chk("rf_error", 32'(error), 32'd0);

        for (int i = 0; i < 6; i++) do_op(OP_PUSH, 32'($urandom));
        for (int i = 0; i < 3; i++) do_op(OP_POP, 32'd0);
        do_op(OP_CLEAR, 32'd0);
        do_op(OP_PUSH, 32'h1234);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
